// File: rtl/l15_resp_model_if.sv
// Transducer <-> L1.5 request/response channel.
// The transducer drives the master side; the L1.5 responder uses the slave side.
interface l15_resp_model_if #(
    parameter int ADDR_WIDTH       = 40,
    parameter int L15_AMO_OP_WIDTH = 4
);
    logic                        transducer_l15_val;
    logic [4:0]                  transducer_l15_rqtype;
    logic [2:0]                  transducer_l15_size;
    logic [ADDR_WIDTH-1:0]       transducer_l15_address;
    logic [63:0]                 transducer_l15_data;
    logic                        transducer_l15_nc;
    logic [L15_AMO_OP_WIDTH-1:0] transducer_l15_amo_op;
    logic                        transducer_l15_req_ack;

    logic                        l15_transducer_header_ack;
    logic                        l15_transducer_ack;
    logic                        l15_transducer_val;
    logic [3:0]                  l15_transducer_returntype;
    logic [63:0]                 l15_transducer_data_0;
    logic [63:0]                 l15_transducer_data_1;

    modport master (
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_amo_op, transducer_l15_req_ack,
        input  l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
               l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
    );

    modport slave (
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_amo_op, transducer_l15_req_ack,
        output l15_transducer_header_ack, l15_transducer_ack, l15_transducer_val,
               l15_transducer_returntype, l15_transducer_data_0, l15_transducer_data_1
    );
endinterface

// File: rtl/l15_resp_model.sv
// Single-outstanding L1.5 stand-in: accepts one load/store, acks it, and returns
// a response from a small 64-bit-word memory after LATENCY cycles.
module l15_resp_model #(
    parameter int ADDR_WIDTH = 40,
    parameter int MEM_WORDS  = 256,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    l15_resp_model_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_BAD} op_t;

    state_t           state;
    op_t              op;
    logic [2:0]       size_q;
    logic [2:0]       off_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic [63:0]      data_q;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      rd0_q, rd1_q;
    logic [63:0]      ld0, ld1;
    logic [3:0]       rtype;
    logic [7:0]       be;

    logic             hdr_ack_q, ack_q, val_q;
    logic [3:0]       rtype_q;
    logic [63:0]      d0_q, d1_q;

    logic [63:0]      mem [MEM_WORDS];

    logic             unused_inputs;
    assign unused_inputs = ^{bus.transducer_l15_nc, bus.transducer_l15_amo_op,
                             bus.transducer_l15_address[ADDR_WIDTH-1:0]};

    assign idx_nxt = idx_q + IDX_W'(1);
    assign ld0     = (op == OP_LOAD) ? mem[idx_q]   : '0;
    assign ld1     = (op == OP_LOAD) ? mem[idx_nxt] : '0;

    always_comb begin
        rtype = 4'hF;
        if (op == OP_LOAD)  rtype = 4'h0;
        if (op == OP_STORE) rtype = 4'h4;
    end

    // Byte enables from size; low address bits below the access size are dropped.
    always_comb begin
        be = 8'hFF;
        case (size_q)
            3'd0:    be = 8'h01 << off_q;
            3'd1:    be = 8'h03 << {off_q[2:1], 1'b0};
            3'd2:    be = 8'h0F << {off_q[2], 2'b00};
            default: be = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_LOAD;
            size_q    <= '0;
            off_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            cnt       <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            hdr_ack_q <= 1'b0;
            ack_q     <= 1'b0;
            val_q     <= 1'b0;
            rtype_q   <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.transducer_l15_val) begin
                        case (bus.transducer_l15_rqtype)
                            5'h00:   op <= OP_LOAD;
                            5'h01:   op <= OP_STORE;
                            default: op <= OP_BAD;
                        endcase
                        size_q    <= bus.transducer_l15_size;
                        off_q     <= bus.transducer_l15_address[2:0];
                        idx_q     <= bus.transducer_l15_address[3 +: IDX_W];
                        data_q    <= bus.transducer_l15_data;
                        hdr_ack_q <= 1'b1;
                        ack_q     <= 1'b1;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    hdr_ack_q <= 1'b0;
                    ack_q     <= 1'b0;
                    cnt       <= CNT_W'(LATENCY - 1);
                    rd0_q     <= ld0;
                    rd1_q     <= ld1;
                    // With unit latency the response is built straight from memory.
                    if (LATENCY == 1) begin
                        val_q   <= 1'b1;
                        rtype_q <= rtype;
                        d0_q    <= ld0;
                        d1_q    <= ld1;
                        state   <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        val_q   <= 1'b1;
                        rtype_q <= rtype;
                        d0_q    <= rd0_q;
                        d1_q    <= rd1_q;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.transducer_l15_req_ack) begin
                        val_q   <= 1'b0;
                        rtype_q <= '0;
                        d0_q    <= '0;
                        d1_q    <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is deliberately not reset; a store commits at the end of ACCEPT.
    always_ff @(posedge clk) begin
        if (state == ACCEPT && op == OP_STORE) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (be[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
            end
        end
    end

    assign bus.l15_transducer_header_ack = hdr_ack_q;
    assign bus.l15_transducer_ack        = ack_q;
    assign bus.l15_transducer_val        = val_q;
    assign bus.l15_transducer_returntype = rtype_q;
    assign bus.l15_transducer_data_0     = d0_q;
    assign bus.l15_transducer_data_1     = d1_q;
endmodule

// File: doc/l15_resp_model.md
# l15_resp_model

Single-outstanding L1.5-side responder for the core/transducer request channel. It accepts one transducer request at a time, acknowledges it, and executes loads and stores against a small internal 64-bit-word memory. After a programmable latency it returns a response and holds it until the transducer acknowledges. It stands in for the L1.5 in tile-level simulation and in a no-cache tile build, and sits directly opposite the tile core interface.

## Interface
- `ADDR_WIDTH`, 40 — request address width (matches `PHY_ADDR_WIDTH`).
- `MEM_WORDS`, 256 — number of 64-bit words; power of two, ≥ 2.
- `LATENCY`, 2 — cycles from the accept cycle to the response valid; must be ≥ 1.

Ports:
- `clk` in 1 — single clock; all logic is rising-edge.
- `rst` in 1 — asynchronous, active-high reset.
- `transducer_l15_val` in 1 — request valid; held by the requester until acked.
- `transducer_l15_rqtype` in 5 — 5'h00 load, 5'h01 store; all other values are unsupported.
- `transducer_l15_size` in 3 — 0 byte, 1 half, 2 word, 3 dword; 4–7 are treated as dword.
- `transducer_l15_address` in ADDR_WIDTH — byte address.
- `transducer_l15_data` in 64 — store data, byte lanes aligned to `address[2:0]`.
- `transducer_l15_nc`, `transducer_l15_amo_op` in 1 / `L15_AMO_OP_WIDTH` — ignored.
- `l15_transducer_header_ack` out 1 — one-cycle pulse on accept.
- `l15_transducer_ack` out 1 — one-cycle pulse on accept, coincident with `header_ack`.
- `l15_transducer_val` out 1 — response valid.
- `l15_transducer_returntype` out 4 — 4'h0 load return, 4'h4 store ack, 4'hF error.
- `l15_transducer_data_0` out 64 — load data, word at the request index.
- `l15_transducer_data_1` out 64 — word at index+1, modulo `MEM_WORDS`.
- `transducer_l15_req_ack` in 1 — transducer consumes the response.

## Operation
- Word index is `address[3+log2(MEM_WORDS)-1:3]`. Higher address bits are ignored, so addresses alias.
- States: IDLE, ACCEPT, WAIT, RESP.
  - IDLE: when `transducer_l15_val`=1, capture rqtype, size, address and data, then go to ACCEPT.
  - ACCEPT: both ack outputs are 1 for exactly this cycle. A store writes memory at the end of this cycle. A load latches `data_0`/`data_1` at the end of this cycle. The latency counter loads `LATENCY-1`. If `LATENCY`=1, go directly to RESP; otherwise go to WAIT.
  - WAIT: decrement the counter; go to RESP when the counter reaches 1.
  - RESP: `l15_transducer_val`=1 with a stable returntype and data. When `transducer_l15_req_ack`=1, go to IDLE.
- Store byte enables:
  - size 0: byte `address[2:0]`.
  - size 1: bytes `{address[2:1],0}` +0..1.
  - size 2: bytes `{address[2],00}` +0..3.
  - size ≥3: all 8 bytes.
  - Misaligned low address bits are truncated.
- Store response: returntype 4'h4, both data outputs 0.
- Load response: returntype 4'h0, full words regardless of size.
- Unsupported rqtype: acked normally, memory is unchanged, response returntype 4'hF with both data outputs 0.
- A request arriving outside IDLE is not sampled. Requester val is a don't-care in ACCEPT, WAIT and RESP.
- `req_ack` outside RESP is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Memory contents are not reset; they are X until written.
- Reset asserted mid-transaction aborts it immediately. Any ack or response in flight is dropped. A store whose ACCEPT edge has already occurred remains written.
- Request val seen at edge N puts ACCEPT (the ack pulses) in cycle N+1. Response val first appears in cycle N+1+`LATENCY`.
- `req_ack` high in response cycle M: val is 0 in cycle M+1 (IDLE). The next request is sampled at the end of M+1, so back-to-back throughput is one request per `LATENCY`+2 cycles minimum.
- A load after a store to the same index returns the stored data, because the write completes in the store's ACCEPT cycle.

## Test plan
- Reset, then store dword 0x1122334455667788 to address 0x40, then load 0x40. Acks pulse one cycle. Responses: returntype 4, then returntype 0 with data_0=0x1122334455667788.
- Store byte 0xAB at address 0x43 over the prior word, then load. data_0=0x11223344AB667788; data_1 is the word at 0x48.
- `LATENCY`=1 and `LATENCY`=4 runs: response val appears exactly `LATENCY` cycles after the ack cycle. With `req_ack` withheld 5 cycles, val and data stay stable until acked.
- rqtype 5'h07 to address 0x40: acked, returntype 4'hF, data 0. A follow-up load of 0x40 returns unchanged data.
- Load at index `MEM_WORDS-1`: data_1 equals word 0 (wrap).
- Assert `rst` during WAIT of a load. All outputs are 0 next cycle. After deassert, a new request completes normally with no stale response.
